// File: rtl/ctrl_flow_pkg.sv
// Shared control-flow definitions: opcode encoding and default datapath width.
// Imported by every block on the decode-to-fetch path.
package ctrl_flow_pkg;

  localparam int CF_WIDTH = 19;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_BEQ  = 3'd1,
    OP_BNE  = 3'd2,
    OP_BLT  = 3'd3,
    OP_BGE  = 3'd4,
    OP_JMP  = 3'd5,
    OP_CALL = 3'd6,
    OP_RET  = 3'd7
  } cf_op_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address LIFO as a circular buffer; pop_data shows the top entry combinationally.
// A push while full silently overwrites the oldest entry; a pop while empty is ignored.
module pc_ras
  import ctrl_flow_pkg::*;
#(
  parameter int WIDTH     = CF_WIDTH,
  parameter int RAS_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_inc;
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] count;

  // wr_ptr is the next free slot; when full it also addresses the oldest entry.
  assign wr_ptr_inc = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
  assign top_ptr    = (wr_ptr == '0) ? LAST : wr_ptr - 1'b1;
  assign empty      = (count == '0);
  assign full       = (count == DEPTH_C);
  assign pop_data   = mem[top_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr_inc;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      wr_ptr <= top_ptr;
      count  <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Registered PC and next-PC branch resolver, one-cycle latency; stall holds all state.
// Return-address stack for CALL/RET is present only when PC_BRANCH_UNIT_RAS_EN is defined.
module pc_branch_unit
  import ctrl_flow_pkg::*;
#(
  parameter int               WIDTH     = CF_WIDTH,
  parameter int               RAS_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] r_a,
  input  logic [WIDTH-1:0] r_b,
  input  logic [WIDTH-1:0] target,
  input  logic             stall,
  output logic [WIDTH-1:0] pc,
  output logic             taken,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  if (RAS_DEPTH < 2) begin : g_depth_check
    $error("pc_branch_unit: RAS_DEPTH must be at least 2");
  end

  cf_op_e           op_e;
  logic [WIDTH-1:0] seq;
  logic [WIDTH-1:0] nxt_pc;
  logic             nxt_taken;
  logic             accept;
  logic             cond_eq;
  logic             cond_lt;

  assign op_e    = cf_op_e'(op);
  assign seq     = pc + 1'b1;
  assign accept  = instr_valid && !stall;
  assign cond_eq = (r_a == r_b);
  assign cond_lt = ($signed(r_a) < $signed(r_b));

`ifdef PC_BRANCH_UNIT_RAS_EN
  logic             ras_push;
  logic             ras_pop;
  logic             ras_empty;
  logic             ras_full;
  logic [WIDTH-1:0] ras_top;
  logic             nxt_ovf;
  logic             nxt_unf;
  logic             ovf_q;
  logic             unf_q;

  pc_ras #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(seq),
    .pop_data (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
`else
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

  always_comb begin
    nxt_pc    = seq;
    nxt_taken = 1'b0;
`ifdef PC_BRANCH_UNIT_RAS_EN
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    nxt_ovf   = 1'b0;
    nxt_unf   = 1'b0;
`endif
    if (accept) begin
      case (op_e)
        OP_BEQ:  if (cond_eq)  begin nxt_pc = target; nxt_taken = 1'b1; end
        OP_BNE:  if (!cond_eq) begin nxt_pc = target; nxt_taken = 1'b1; end
        OP_BLT:  if (cond_lt)  begin nxt_pc = target; nxt_taken = 1'b1; end
        OP_BGE:  if (!cond_lt) begin nxt_pc = target; nxt_taken = 1'b1; end
        OP_JMP:  begin nxt_pc = target; nxt_taken = 1'b1; end
        OP_CALL: begin
          nxt_pc    = target;
          nxt_taken = 1'b1;
`ifdef PC_BRANCH_UNIT_RAS_EN
          ras_push  = 1'b1;
          nxt_ovf   = ras_full;
`endif
        end
        OP_RET: begin
`ifdef PC_BRANCH_UNIT_RAS_EN
          // An empty stack falls through to seq rather than jumping to stale storage.
          if (ras_empty) begin
            nxt_unf = 1'b1;
          end else begin
            ras_pop   = 1'b1;
            nxt_pc    = ras_top;
            nxt_taken = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      taken <= 1'b0;
    end else if (stall) begin
      taken <= 1'b0;
    end else begin
      pc    <= nxt_pc;
      taken <= nxt_taken;
    end
  end

`ifdef PC_BRANCH_UNIT_RAS_EN
  always_ff @(posedge clk) begin
    if (rst || stall) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= nxt_ovf;
      unf_q <= nxt_unf;
    end
  end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed vector bench for pc_branch_unit; expectations switch on PC_BRANCH_UNIT_RAS_EN.
module tb_pc_branch_unit;
  import ctrl_flow_pkg::*;

  localparam int W = 19;

  logic         clk = 1'b0;
  logic         rst;
  logic         instr_valid;
  logic [2:0]   op;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] target;
  logic         stall;
  logic [W-1:0] pc;
  logic         taken;
  logic         ras_overflow;
  logic         ras_underflow;

  always #5 clk = ~clk;

  pc_branch_unit #(
    .WIDTH    (W),
    .RAS_DEPTH(8),
    .RESET_PC (19'h00010)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .op           (op),
    .r_a          (r_a),
    .r_b          (r_b),
    .target       (target),
    .stall        (stall),
    .pc           (pc),
    .taken        (taken),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow)
  );

  typedef struct {
    string        name;
    logic         rst;
    logic         vld;
    logic         stall;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] tgt;
    logic [W-1:0] pc;
    logic         tk;
    logic         ov;
    logic         un;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // pe/te/oe/ue: expectation with the RAS built in; pd/td: expectation without it.
  task automatic add(input string nm, input logic r, input logic v, input logic s,
                     input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] t, input logic [W-1:0] pe, input logic te,
                     input logic oe, input logic ue, input logic [W-1:0] pd, input logic td);
    vec_t x;
    x.name = nm; x.rst = r; x.vld = v; x.stall = s; x.op = o;
    x.a = a; x.b = b; x.tgt = t;
`ifdef PC_BRANCH_UNIT_RAS_EN
    x.pc = pe; x.tk = te; x.ov = oe; x.un = ue;
`else
    x.pc = pd; x.tk = td; x.ov = 1'b0; x.un = 1'b0;
`endif
    vecs.push_back(x);
  endtask

  task automatic chk(input string nm, input string f, input logic [W-1:0] got,
                     input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s got %h want %h", nm, f, got, want);
    end
  endtask

  task automatic apply(input vec_t x);
    rst = x.rst; instr_valid = x.vld; stall = x.stall; op = x.op;
    r_a = x.a; r_b = x.b; target = x.tgt;
    @(posedge clk);
    #1;
    chk(x.name, "pc", pc, x.pc);
    chk(x.name, "taken", W'(taken), W'(x.tk));
    chk(x.name, "ras_overflow", W'(ras_overflow), W'(x.ov));
    chk(x.name, "ras_underflow", W'(ras_underflow), W'(x.un));
  endtask

  task automatic run_all();
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; stall = 1'b0; op = '0;
    r_a = '0; r_b = '0; target = '0;

    //   name        rst v s  op       r_a      r_b   target     pc(ras)  tk ov un  pc(noras) tk
    add("reset",      1, 0, 0, OP_NOP,  0,       0,    0,         'h10,    0, 0, 0, 'h10,     0);
    add("idle1",      0, 0, 0, OP_JMP,  0,       0,    'h7777,    'h11,    0, 0, 0, 'h11,     0);
    add("idle2",      0, 0, 0, OP_JMP,  0,       0,    'h7777,    'h12,    0, 0, 0, 'h12,     0);
    add("idle3",      0, 0, 0, OP_JMP,  0,       0,    'h7777,    'h13,    0, 0, 0, 'h13,     0);
    add("jmp20",      0, 1, 0, OP_JMP,  0,       0,    'h20,      'h20,    1, 0, 0, 'h20,     1);
    add("beq_eq",     0, 1, 0, OP_BEQ,  5,       5,    'h100,     'h100,   1, 0, 0, 'h100,    1);
    add("bne_eq",     0, 1, 0, OP_BNE,  5,       5,    'h200,     'h101,   0, 0, 0, 'h101,    0);
    add("blt_neg",    0, 1, 0, OP_BLT,  'h7FFFF, 1,    'h200,     'h200,   1, 0, 0, 'h200,    1);
    add("bge_neg",    0, 1, 0, OP_BGE,  'h7FFFF, 1,    'h300,     'h201,   0, 0, 0, 'h201,    0);
    add("bge_pos",    0, 1, 0, OP_BGE,  1,       'h7FFFF, 'h300,  'h300,   1, 0, 0, 'h300,    1);
    add("blt_equal",  0, 1, 0, OP_BLT,  3,       3,    'h700,     'h301,   0, 0, 0, 'h301,    0);
    add("jmp30",      0, 1, 0, OP_JMP,  0,       0,    'h30,      'h30,    1, 0, 0, 'h30,     1);
    add("call400",    0, 1, 0, OP_CALL, 0,       0,    'h400,     'h400,   1, 0, 0, 'h400,    1);
    add("ret_once",   0, 1, 0, OP_RET,  0,       0,    'h555,     'h31,    1, 0, 0, 'h401,    0);
    add("jmp40",      0, 1, 0, OP_JMP,  0,       0,    'h40,      'h40,    1, 0, 0, 'h40,     1);
    for (int k = 1; k <= 8; k++)
      add($sformatf("call_fill%0d", k), 0, 1, 0, OP_CALL, 0, 0, W'(k * 'h100),
          W'(k * 'h100), 1, 0, 0, W'(k * 'h100), 1);
    add("call_ovf",   0, 1, 0, OP_CALL, 0,       0,    'h900,     'h900,   1, 1, 0, 'h900,    1);
    add("nop_ovf_clr",0, 1, 0, OP_NOP,  0,       0,    'h123,     'h901,   0, 0, 0, 'h901,    0);
    for (int j = 0; j < 8; j++)
      add($sformatf("ret_drain%0d", j), 0, 1, 0, OP_RET, 0, 0, 'h555,
          W'('h801 - j * 'h100), 1, 0, 0, W'('h902 + j), 0);
    add("ret_empty",  0, 1, 0, OP_RET,  0,       0,    'h555,     'h102,   0, 0, 1, 'h90A,    0);
    add("jmp_max",    0, 1, 0, OP_JMP,  0,       0,    'h7FFFF,   'h7FFFF, 1, 0, 0, 'h7FFFF,  1);
    add("pc_wrap",    0, 0, 0, OP_NOP,  0,       0,    0,         'h0,     0, 0, 0, 'h0,      0);
    add("stall1",     0, 1, 1, OP_BEQ,  5,       5,    'h100,     'h0,     0, 0, 0, 'h0,      0);
    add("stall2",     0, 1, 1, OP_BEQ,  5,       5,    'h100,     'h0,     0, 0, 0, 'h0,      0);
    add("stall3",     0, 1, 1, OP_BEQ,  5,       5,    'h100,     'h0,     0, 0, 0, 'h0,      0);
    add("unstall_beq",0, 1, 0, OP_BEQ,  5,       5,    'h100,     'h100,   1, 0, 0, 'h100,    1);
    add("callA",      0, 1, 0, OP_CALL, 0,       0,    'h200,     'h200,   1, 0, 0, 'h200,    1);
    add("callB",      0, 1, 0, OP_CALL, 0,       0,    'h300,     'h300,   1, 0, 0, 'h300,    1);
    add("callC",      0, 1, 0, OP_CALL, 0,       0,    'h400,     'h400,   1, 0, 0, 'h400,    1);
    add("rst_w_ret",  1, 1, 0, OP_RET,  0,       0,    0,         'h10,    0, 0, 0, 'h10,     0);
    add("ret_post_rst",0,1, 0, OP_RET,  0,       0,    0,         'h11,    0, 0, 1, 'h11,     0);
    add("rst_over_stall",1,1,1, OP_JMP, 0,       0,    'h777,     'h10,    0, 0, 0, 'h10,     0);
    run_all();

    // Stall must not push; the following RET returns the pre-stall CALL's address.
    add("call500",    0, 1, 0, OP_CALL, 0,       0,    'h500,     'h500,   1, 0, 0, 'h500,    1);
    add("stall_call", 0, 1, 1, OP_CALL, 0,       0,    'h600,     'h500,   0, 0, 0, 'h500,    0);
    add("ret_to_11",  0, 1, 0, OP_RET,  0,       0,    0,         'h11,    1, 0, 0, 'h501,    0);
    add("ret_empty2", 0, 1, 0, OP_RET,  0,       0,    0,         'h12,    0, 0, 1, 'h502,    0);
    run_all();

    // taken falls when a stall follows a branch; empty RET at all-ones wraps.
    add("jmp_max2",   0, 1, 0, OP_JMP,  0,       0,    'h7FFFF,   'h7FFFF, 1, 0, 0, 'h7FFFF,  1);
    add("ret_wrap",   0, 1, 0, OP_RET,  0,       0,    0,         'h0,     0, 0, 1, 'h0,      0);
    add("jmp50",      0, 1, 0, OP_JMP,  0,       0,    'h50,      'h50,    1, 0, 0, 'h50,     1);
    add("stall_jmp",  0, 1, 1, OP_JMP,  0,       0,    'h60,      'h50,    0, 0, 0, 'h50,     0);
    add("idle_after", 0, 0, 0, OP_JMP,  0,       0,    'h60,      'h51,    0, 0, 0, 'h51,     0);
    run_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Registered program-counter and branch-resolution unit for the 19-bit control-flow datapath. It generalises the combinational branch-equal selector into a multi-condition (EQ/NE/LT/GE/JMP/CALL/RET) next-PC engine. It holds the PC in a register and keeps an optional return-address stack (RAS). It sits between decode (operands, target, opcode) and instruction fetch (pc).

## Interface
- WIDTH, 19: PC, operand and target width.
- RAS_DEPTH, 8: return-address stack entries, at least 2.
- RESET_PC, 0: PC value loaded on reset.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_valid  input  1  op/r_a/r_b/target are valid this cycle.
- op  input  3  0 NOP, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 JMP, 6 CALL, 7 RET.
- r_a  input  WIDTH  first compare operand.
- r_b  input  WIDTH  second compare operand.
- target  input  WIDTH  branch/jump/call destination.
- stall  input  1  hold all state; instr_valid is ignored.
- pc  output  WIDTH  current PC (registered).
- taken  output  1  one-cycle pulse: the last accepted instruction redirected the PC.
- ras_overflow  output  1  one-cycle pulse: CALL pushed onto a full RAS.
- ras_underflow  output  1  one-cycle pulse: RET issued with the RAS empty.

## Operation
- seq = pc + 1, truncated to WIDTH; wraps from all-ones to 0.
- An instruction is accepted when instr_valid=1, stall=0 and rst=0.
- Next-PC selection for an accepted instruction:
  - NOP: seq.
  - BEQ: target if r_a==r_b, else seq.
  - BNE: target if r_a!=r_b, else seq.
  - BLT: target if $signed(r_a) < $signed(r_b), else seq.
  - BGE: target if $signed(r_a) >= $signed(r_b), else seq.
  - JMP: target, unconditionally.
  - CALL: push seq onto the RAS, then go to target.
  - RET: pop the RAS and go to the popped value; if the RAS is empty, go to seq and raise ras_underflow.
- No accepted instruction and stall=0: pc <= seq; taken=0.
- stall=1: pc, RAS contents and RAS count hold; taken=0; both flags=0.
- taken=1 for one cycle only when the next PC came from target or from a RAS pop.
- RAS structure: circular buffer with a top pointer and a count in 0..RAS_DEPTH.
- CALL with RAS full: the oldest entry is overwritten; count stays RAS_DEPTH; ras_overflow pulses; the jump still happens.
- Only one instruction is accepted per cycle, so a push and a pop never occur in the same cycle.

## Timing
- Reset values (applied on the edge where rst=1): pc=RESET_PC, taken=0, ras_overflow=0, ras_underflow=0, RAS count=0.
- rst has priority over stall and instr_valid.
- Reset mid-operation discards all RAS entries; the contents of RAS storage afterwards are don't-care.
- Latency: one cycle. Inputs sampled at edge N appear on pc, taken and the flags after edge N.
- Flags and taken are registered alongside pc; they are never combinational from the inputs.

## Configuration
- Macro: PC_BRANCH_UNIT_RAS_EN.
- Defined: RAS and CALL/RET behave as described above.
- Undefined: no RAS storage. CALL behaves exactly as JMP. RET behaves as NOP (pc <= seq, taken=0). ras_overflow and ras_underflow are tied to 0.

## Structure
- Shared package ctrl_flow_pkg holds:
  - the 3-bit op enum, with values as listed under Interface;
  - the WIDTH=19 default constant used across the control-flow blocks.
- Sub-module pc_ras: parameterised LIFO (WIDTH, RAS_DEPTH).
  - Ports: push, pop, push_data, pop_data, empty, full.
  - Instantiated only under PC_BRANCH_UNIT_RAS_EN.

## Test plan
- Reset with RESET_PC=0x00010: pc=0x00010 and taken=0 after the reset edge; three idle cycles give pc=0x00011, 0x00012, 0x00013.
- At pc=0x00020, BEQ r_a=r_b=5, target=0x00100 → pc=0x00100, taken=1 for one cycle. Then BNE r_a=r_b=5 → pc=0x00101, taken=0.
- BLT r_a=0x7FFFF (−1), r_b=1, target=0x00200 → taken, pc=0x00200. BGE with the same operands → not taken.
- At pc=0x00030, CALL target=0x00400, then RET → pc=0x00400, then pc=0x00031. Fill 8 CALLs then a 9th CALL → ras_overflow pulses once. Next 8 RETs return the newest 8 return addresses; the 9th RET gives ras_underflow=1 and pc=seq.
- pc=0x7FFFF, idle cycle → pc=0x00000. stall=1 held for 3 cycles with a BEQ presented → pc unchanged, taken=0.
- Push 3 CALLs, then assert rst together with a RET → pc=RESET_PC. A following RET gives ras_underflow=1. Repeat with PC_BRANCH_UNIT_RAS_EN undefined: CALL jumps to target, RET advances to seq, flags stay 0.
